core_mem_stage: RTL and testbench
=================================

# core_mem_stage

Memory (M) stage of the five-stage core pipeline. Consumes the `m_if` master end and drives the `w_if` slave end. Issues loads and stores to a single-outstanding data bus, steers byte lanes for stores, and right-aligns load data. Non-memory instructions pass through to writeback with one cycle of latency.

## Interface
Parameters:
- none

Ports:
- `clk`  in  1  core clock; all state changes on the rising edge.
- `rst_n`  in  1  synchronous active-low reset.
- `m`  `m_if.master`  –  request from X stage.
  - Inputs: valid, pc, imm, rs2, rd, reg_wen, reg_wsel, alu_out (effective address), mem_type (funct3), mem_ren, mem_wen.
  - Output: ready.
- `w`  `w_if.slave`  –  result to W stage.
  - Outputs: valid, pc, imm, rd, reg_wen, reg_wsel, alu_out, mem_type, mem_rdata.
  - Input: ready.
- `dbus_req`  out  1  request valid; held until granted.
- `dbus_we`  out  1  1 = store.
- `dbus_addr`  out  32  word address; bits [1:0] are always 0.
- `dbus_be`  out  4  byte enables (stores); 4'b1111 on loads.
- `dbus_wdata`  out  32  lane-replicated store data.
- `dbus_gnt`  in  1  request accepted this cycle.
- `dbus_rvalid`  in  1  load data valid; at most one per granted load.
- `dbus_rdata`  in  32  load data.
- `mem_fault`  out  1  misaligned access; only present under `CORE_MEM_MISALIGN_EN`.

## Operation
FSM states: IDLE, REQ, WAIT, HOLD.

- **IDLE**
  - `m.ready = (!w.valid || w.ready)`.
  - A handshake `m.valid && m.ready` captures all fields.
    - Non-memory instruction: load the output register directly; `w.valid`=1. Stay in IDLE.
    - Memory instruction: go to REQ.
- **REQ**
  - `dbus_req`=1 with stable addr/we/be/wdata.
  - On `dbus_gnt`:
    - store: load the output register; go to HOLD.
    - load: go to WAIT.
- **WAIT**
  - `dbus_req`=0.
  - On `dbus_rvalid`: `w.mem_rdata = dbus_rdata >> (8*alu_out[1:0])`; go to HOLD.
- **HOLD**
  - `w.valid`=1 until `w.ready`; then go to IDLE.
  - `m.ready` in HOLD is 0.
- Output register behaviour in IDLE: `w.valid` clears when `w.ready` is high and no new handshake occurs. Back-to-back non-memory instructions sustain 1/cycle while `w.ready`=1.
- Store lane rules (`off = alu_out[1:0]`):
  - SB (000): be=`4'b0001<<off`, wdata=`{4{rs2[7:0]}}`.
  - SH (001): be=`4'b0011<<off`, wdata=`{2{rs2[15:0]}}`.
  - SW (010): be=`4'b1111`.
- Loads: sign/zero extension is done in W from `w.mem_type`. This stage only right-aligns the data.
- `w.mem_rdata`=0 for stores and non-memory instructions.
- Protocol rules:
  - `dbus_rvalid` outside WAIT is ignored.
  - `mem_ren` and `mem_wen` both set is treated as a store.
- Reset (`rst_n`=0 at an edge):
  - state→IDLE; `w.valid`, `dbus_req`, `mem_fault` →0; data registers →0.
  - `m.ready` is forced 0 while `rst_n`=0.
  - A reset in REQ or WAIT abandons the access; a late `rvalid` is discarded.

## Timing
- Non-memory: accept at edge N → `w.valid` visible after edge N.
- Store: accept at N → `dbus_req` high after N; grant at edge G → `w.valid` after G.
- Load: grant at G; `rvalid` at edge R>G → `w.valid` and data after R.
- Minimum memory latency, accept to `w.valid`:
  - store: 2 cycles.
  - load: 3 cycles.
- All outputs are registered except `m.ready`, which is combinational from state, `w.valid` and `w.ready`.
- Request fields never change while `dbus_req`=1 and `dbus_gnt`=0.

## Configuration
`CORE_MEM_MISALIGN_EN`:
- **Defined:** a halfword with `off[0]`=1, or a word with `off`≠0, issues no bus request.
  - The instruction goes straight to the output register with `reg_wen` forced 0.
  - `mem_fault`=1 for the cycle `w.valid` first rises.
- **Undefined:**
  - `mem_fault` is absent.
  - The address is force-aligned: halfword `off[0]`→0, word `off`→0.
  - The access is performed at the aligned address.

## Test plan
- Reset, then 3 back-to-back ALU ops (`w.ready`=1) → `w.valid` on 3 consecutive cycles; `dbus_req` stays 0.
- SB rs2=0xA5 at addr 0x1003, gnt delayed 2 cycles → `dbus_addr`=0x1000, be=1000, wdata=0xA5A5A5A5 held stable; `w.valid` 1 cycle after gnt.
- LH at 0x2002, rdata=0x8001_1234, `rvalid` 3 cycles after gnt → `w.mem_rdata`=0x0000_8001, `w.mem_type`=001.
- Load completes with `w.ready`=0 for 4 cycles → `w.valid` and data held; `m.ready`=0 throughout; next accept on the cycle after `w.ready`.
- Reset asserted in WAIT, `rvalid` arrives after reset → `w.valid`=0, state IDLE, `m.ready`=1.
- LW at 0x3001:
  - with macro → no `dbus_req`, `mem_fault`=1, `w.reg_wen`=0.
  - without macro → `dbus_addr`=0x3000.

Source files
------------

// File: rtl/core_mem_stage.sv
// core_mem_stage: M stage of the five-stage core; single-outstanding data bus master.
// Build macro CORE_MEM_MISALIGN_EN traps misaligned accesses (mem_fault_o) instead of force-aligning them.
module core_mem_stage (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        m_valid_i,
    input  logic [31:0] m_pc_i,
    input  logic [31:0] m_imm_i,
    input  logic [31:0] m_rs2_i,
    input  logic [4:0]  m_rd_i,
    input  logic        m_reg_wen_i,
    input  logic [1:0]  m_reg_wsel_i,
    input  logic [31:0] m_alu_out_i,
    input  logic [2:0]  m_mem_type_i,
    input  logic        m_mem_ren_i,
    input  logic        m_mem_wen_i,
    output logic        m_ready_o,
    output logic        w_valid_o,
    output logic [31:0] w_pc_o,
    output logic [31:0] w_imm_o,
    output logic [4:0]  w_rd_o,
    output logic        w_reg_wen_o,
    output logic [1:0]  w_reg_wsel_o,
    output logic [31:0] w_alu_out_o,
    output logic [2:0]  w_mem_type_o,
    output logic [31:0] w_mem_rdata_o,
    input  logic        w_ready_i,
    output logic        dbus_req_o,
    output logic        dbus_we_o,
    output logic [31:0] dbus_addr_o,
    output logic [3:0]  dbus_be_o,
    output logic [31:0] dbus_wdata_o,
    input  logic        dbus_gnt_i,
    input  logic        dbus_rvalid_i,
`ifdef CORE_MEM_MISALIGN_EN
    output logic        mem_fault_o,
`endif
    input  logic [31:0] dbus_rdata_i
);

    localparam int unsigned XLEN  = 32;
    localparam int unsigned REGW  = 5;
    localparam int unsigned WSELW = 2;
    localparam int unsigned F3W   = 3;
    localparam int unsigned BEW   = 4;

    typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_WAIT, ST_HOLD} state_e;

    // Byte offset actually used on the bus: halfwords drop bit 0, words drop both bits.
    function automatic logic [1:0] align_off(input logic [1:0] sz, input logic [1:0] off);
        case (sz)
            2'b00:   align_off = off;
            2'b01:   align_off = {off[1], 1'b0};
            default: align_off = 2'b00;
        endcase
    endfunction

    state_e            state_q, state_d;
    logic              w_valid_q, w_valid_d;
    logic [XLEN-1:0]   w_pc_q, w_pc_d;
    logic [XLEN-1:0]   w_imm_q, w_imm_d;
    logic [REGW-1:0]   w_rd_q, w_rd_d;
    logic              w_reg_wen_q, w_reg_wen_d;
    logic [WSELW-1:0]  w_reg_wsel_q, w_reg_wsel_d;
    logic [XLEN-1:0]   w_alu_out_q, w_alu_out_d;
    logic [F3W-1:0]    w_mem_type_q, w_mem_type_d;
    logic [XLEN-1:0]   w_mem_rdata_q, w_mem_rdata_d;
    logic              dbus_req_q, dbus_req_d;
    logic              dbus_we_q, dbus_we_d;
    logic [XLEN-1:0]   dbus_addr_q, dbus_addr_d;
    logic [BEW-1:0]    dbus_be_q, dbus_be_d;
    logic [XLEN-1:0]   dbus_wdata_q, dbus_wdata_d;
`ifdef CORE_MEM_MISALIGN_EN
    logic              mem_fault_q, mem_fault_d;
    logic              misalign_c;
`endif

    logic              is_mem_c;
    logic [1:0]        m_off_c;
    logic [BEW-1:0]    st_be_c;
    logic [XLEN-1:0]   st_wdata_c;

    assign m_ready_o = rst_n && (state_q == ST_IDLE) && (!w_valid_q || w_ready_i);
    assign is_mem_c  = m_mem_ren_i || m_mem_wen_i;
    assign m_off_c   = align_off(m_mem_type_i[1:0], m_alu_out_i[1:0]);

    // Store lane steering: replicate data across lanes, enable only the addressed bytes.
    always_comb begin
        st_be_c    = 4'b1111;
        st_wdata_c = m_rs2_i;
        case (m_mem_type_i[1:0])
            2'b00: begin
                st_be_c    = BEW'(4'b0001 << m_off_c);
                st_wdata_c = {4{m_rs2_i[7:0]}};
            end
            2'b01: begin
                st_be_c    = BEW'(4'b0011 << m_off_c);
                st_wdata_c = {2{m_rs2_i[15:0]}};
            end
            default: ;
        endcase
    end

`ifdef CORE_MEM_MISALIGN_EN
    assign misalign_c = ((m_mem_type_i[1:0] == 2'b01) && m_alu_out_i[0]) ||
                        (m_mem_type_i[1] && (m_alu_out_i[1:0] != 2'b00));
`endif

    // Next-state and output-register logic.
    always_comb begin
        state_d       = state_q;
        w_valid_d     = w_valid_q;
        w_pc_d        = w_pc_q;
        w_imm_d       = w_imm_q;
        w_rd_d        = w_rd_q;
        w_reg_wen_d   = w_reg_wen_q;
        w_reg_wsel_d  = w_reg_wsel_q;
        w_alu_out_d   = w_alu_out_q;
        w_mem_type_d  = w_mem_type_q;
        w_mem_rdata_d = w_mem_rdata_q;
        dbus_req_d    = dbus_req_q;
        dbus_we_d     = dbus_we_q;
        dbus_addr_d   = dbus_addr_q;
        dbus_be_d     = dbus_be_q;
        dbus_wdata_d  = dbus_wdata_q;
`ifdef CORE_MEM_MISALIGN_EN
        mem_fault_d   = 1'b0;
`endif
        unique case (state_q)
            ST_IDLE: begin
                if (w_ready_i) w_valid_d = 1'b0;
                if (m_ready_o && m_valid_i) begin
                    w_pc_d        = m_pc_i;
                    w_imm_d       = m_imm_i;
                    w_rd_d        = m_rd_i;
                    w_reg_wen_d   = m_reg_wen_i;
                    w_reg_wsel_d  = m_reg_wsel_i;
                    w_alu_out_d   = m_alu_out_i;
                    w_mem_type_d  = m_mem_type_i;
                    w_mem_rdata_d = '0;
                    dbus_we_d     = m_mem_wen_i;
                    dbus_addr_d   = {m_alu_out_i[XLEN-1:2], 2'b00};
                    dbus_be_d     = m_mem_wen_i ? st_be_c : 4'b1111;
                    dbus_wdata_d  = st_wdata_c;
                    if (!is_mem_c) begin
                        w_valid_d = 1'b1;
                    end
`ifdef CORE_MEM_MISALIGN_EN
                    else if (misalign_c) begin
                        w_valid_d   = 1'b1;
                        w_reg_wen_d = 1'b0;
                        mem_fault_d = 1'b1;
                    end
`endif
                    else begin
                        w_valid_d  = 1'b0;
                        dbus_req_d = 1'b1;
                        state_d    = ST_REQ;
                    end
                end
            end
            ST_REQ: begin
                if (dbus_gnt_i) begin
                    dbus_req_d = 1'b0;
                    if (dbus_we_q) begin
                        w_valid_d = 1'b1;
                        state_d   = ST_HOLD;
                    end else begin
                        state_d   = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                if (dbus_rvalid_i) begin
                    w_mem_rdata_d = dbus_rdata_i >>
                        {align_off(w_mem_type_q[1:0], w_alu_out_q[1:0]), 3'b000};
                    w_valid_d     = 1'b1;
                    state_d       = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (w_ready_i) begin
                    w_valid_d = 1'b0;
                    state_d   = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            w_valid_q     <= 1'b0;
            w_pc_q        <= '0;
            w_imm_q       <= '0;
            w_rd_q        <= '0;
            w_reg_wen_q   <= 1'b0;
            w_reg_wsel_q  <= '0;
            w_alu_out_q   <= '0;
            w_mem_type_q  <= '0;
            w_mem_rdata_q <= '0;
            dbus_req_q    <= 1'b0;
            dbus_we_q     <= 1'b0;
            dbus_addr_q   <= '0;
            dbus_be_q     <= '0;
            dbus_wdata_q  <= '0;
`ifdef CORE_MEM_MISALIGN_EN
            mem_fault_q   <= 1'b0;
`endif
        end else begin
            state_q       <= state_d;
            w_valid_q     <= w_valid_d;
            w_pc_q        <= w_pc_d;
            w_imm_q       <= w_imm_d;
            w_rd_q        <= w_rd_d;
            w_reg_wen_q   <= w_reg_wen_d;
            w_reg_wsel_q  <= w_reg_wsel_d;
            w_alu_out_q   <= w_alu_out_d;
            w_mem_type_q  <= w_mem_type_d;
            w_mem_rdata_q <= w_mem_rdata_d;
            dbus_req_q    <= dbus_req_d;
            dbus_we_q     <= dbus_we_d;
            dbus_addr_q   <= dbus_addr_d;
            dbus_be_q     <= dbus_be_d;
            dbus_wdata_q  <= dbus_wdata_d;
`ifdef CORE_MEM_MISALIGN_EN
            mem_fault_q   <= mem_fault_d;
`endif
        end
    end

    assign w_valid_o     = w_valid_q;
    assign w_pc_o        = w_pc_q;
    assign w_imm_o       = w_imm_q;
    assign w_rd_o        = w_rd_q;
    assign w_reg_wen_o   = w_reg_wen_q;
    assign w_reg_wsel_o  = w_reg_wsel_q;
    assign w_alu_out_o   = w_alu_out_q;
    assign w_mem_type_o  = w_mem_type_q;
    assign w_mem_rdata_o = w_mem_rdata_q;
    assign dbus_req_o    = dbus_req_q;
    assign dbus_we_o     = dbus_we_q;
    assign dbus_addr_o   = dbus_addr_q;
    assign dbus_be_o     = dbus_be_q;
    assign dbus_wdata_o  = dbus_wdata_q;
`ifdef CORE_MEM_MISALIGN_EN
    assign mem_fault_o   = mem_fault_q;
`endif

endmodule

// File: tb/tb_core_mem_stage.sv
// tb_core_mem_stage: directed and random stimulus for core_mem_stage against a transaction-level model.
// Honours CORE_MEM_MISALIGN_EN the same way as the design.
module tb_core_mem_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        m_valid, m_reg_wen, m_mem_ren, m_mem_wen, m_ready;
    logic [31:0] m_pc, m_imm, m_rs2, m_alu_out;
    logic [4:0]  m_rd;
    logic [1:0]  m_reg_wsel;
    logic [2:0]  m_mem_type;
    logic        w_valid, w_reg_wen, w_ready;
    logic [31:0] w_pc, w_imm, w_alu_out, w_mem_rdata;
    logic [4:0]  w_rd;
    logic [1:0]  w_reg_wsel;
    logic [2:0]  w_mem_type;
    logic        dbus_req, dbus_we, dbus_gnt, dbus_rvalid;
    logic [31:0] dbus_addr, dbus_wdata, dbus_rdata;
    logic [3:0]  dbus_be;
`ifdef CORE_MEM_MISALIGN_EN
    logic        mem_fault;
`endif

    always #5 clk = ~clk;

    core_mem_stage dut (
        .clk(clk), .rst_n(rst_n),
        .m_valid_i(m_valid), .m_pc_i(m_pc), .m_imm_i(m_imm), .m_rs2_i(m_rs2),
        .m_rd_i(m_rd), .m_reg_wen_i(m_reg_wen), .m_reg_wsel_i(m_reg_wsel),
        .m_alu_out_i(m_alu_out), .m_mem_type_i(m_mem_type),
        .m_mem_ren_i(m_mem_ren), .m_mem_wen_i(m_mem_wen), .m_ready_o(m_ready),
        .w_valid_o(w_valid), .w_pc_o(w_pc), .w_imm_o(w_imm), .w_rd_o(w_rd),
        .w_reg_wen_o(w_reg_wen), .w_reg_wsel_o(w_reg_wsel), .w_alu_out_o(w_alu_out),
        .w_mem_type_o(w_mem_type), .w_mem_rdata_o(w_mem_rdata), .w_ready_i(w_ready),
        .dbus_req_o(dbus_req), .dbus_we_o(dbus_we), .dbus_addr_o(dbus_addr),
        .dbus_be_o(dbus_be), .dbus_wdata_o(dbus_wdata), .dbus_gnt_i(dbus_gnt),
        .dbus_rvalid_i(dbus_rvalid),
`ifdef CORE_MEM_MISALIGN_EN
        .mem_fault_o(mem_fault),
`endif
        .dbus_rdata_i(dbus_rdata)
    );

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] imm;
        logic [4:0]  rd;
        logic        wen;
        logic [1:0]  wsel;
        logic [31:0] alu;
        logic [2:0]  mt;
        logic [31:0] rdata;
    } wres_t;

    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;

    // Model: one pending writeback slot plus at most one bus transaction in flight.
    wres_t       out_e, pend_e;
    bit          out_v, busy, req_p, data_p, fault_e;
    bit          bus_we_e;
    logic [31:0] bus_addr_e, bus_wdata_e;
    logic [3:0]  bus_be_e;
    int unsigned pend_shift;
    logic [2:0]  ld_types [5];

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        busy = 0; req_p = 0; data_p = 0; out_v = 0; fault_e = 0;
        out_e = '0; pend_e = '0;
    endtask

    // Called at a falling edge with inputs already driven; returns at the next falling edge.
    task automatic cycle();
        bit exp_ready;
        check_eq("w_valid", 32'(w_valid), 32'(out_v));
        if (out_v) begin
            check_eq("w_pc", w_pc, out_e.pc);
            check_eq("w_imm", w_imm, out_e.imm);
            check_eq("w_rd", 32'(w_rd), 32'(out_e.rd));
            check_eq("w_reg_wen", 32'(w_reg_wen), 32'(out_e.wen));
            check_eq("w_reg_wsel", 32'(w_reg_wsel), 32'(out_e.wsel));
            check_eq("w_alu_out", w_alu_out, out_e.alu);
            check_eq("w_mem_type", 32'(w_mem_type), 32'(out_e.mt));
            check_eq("w_mem_rdata", w_mem_rdata, out_e.rdata);
        end
        check_eq("dbus_req", 32'(dbus_req), 32'(req_p));
        if (req_p) begin
            check_eq("dbus_addr", dbus_addr, bus_addr_e);
            check_eq("dbus_be", 32'(dbus_be), 32'(bus_be_e));
            check_eq("dbus_we", 32'(dbus_we), 32'(bus_we_e));
            if (bus_we_e) check_eq("dbus_wdata", dbus_wdata, bus_wdata_e);
        end
`ifdef CORE_MEM_MISALIGN_EN
        check_eq("mem_fault", 32'(mem_fault), 32'(fault_e));
`endif
        #1;
        if (!rst_n) begin
            check_eq("m_ready_rst", 32'(m_ready), 32'd0);
            model_reset();
        end else begin
            exp_ready = !busy && (!out_v || w_ready);
            check_eq("m_ready", 32'(m_ready), 32'(exp_ready));
            fault_e = 0;
            if (out_v && w_ready) begin
                out_v = 0;
                if (busy && !req_p && !data_p) busy = 0;
            end
            if (req_p && dbus_gnt) begin
                req_p = 0;
                if (bus_we_e) begin
                    out_v = 1;
                    out_e = pend_e;
                end else begin
                    data_p = 1;
                end
            end else if (data_p && dbus_rvalid) begin
                data_p = 0;
                out_v = 1;
                out_e = pend_e;
                out_e.rdata = dbus_rdata >> pend_shift;
            end
            if (exp_ready && m_valid) begin
                wres_t r;
                int unsigned nb, aoff;
                r = '{pc: m_pc, imm: m_imm, rd: m_rd, wen: m_reg_wen, wsel: m_reg_wsel,
                      alu: m_alu_out, mt: m_mem_type, rdata: 32'd0};
                nb   = (m_mem_type[1:0] == 2'b00) ? 1 : (m_mem_type[1:0] == 2'b01) ? 2 : 4;
                aoff = 32'(m_alu_out[1:0]) & ~(nb - 1);
                if (!(m_mem_ren || m_mem_wen)) begin
                    out_v = 1;
                    out_e = r;
                end else
`ifdef CORE_MEM_MISALIGN_EN
                if ((32'(m_alu_out[1:0]) % nb) != 0) begin
                    r.wen   = 1'b0;
                    out_v   = 1;
                    out_e   = r;
                    fault_e = 1;
                end else
`endif
                begin
                    busy        = 1;
                    req_p       = 1;
                    pend_e      = r;
                    bus_we_e    = m_mem_wen;
                    bus_addr_e  = m_alu_out & ~32'h3;
                    bus_be_e    = m_mem_wen ? 4'(((32'd1 << nb) - 1) << aoff) : 4'hF;
                    bus_wdata_e = (nb == 1) ? 32'(m_rs2[7:0]) * 32'h0101_0101 :
                                  (nb == 2) ? 32'(m_rs2[15:0]) * 32'h0001_0001 : m_rs2;
                    pend_shift  = 8 * aoff;
                end
            end
        end
        @(negedge clk);
    endtask

    task automatic set_instr(input bit ren, input bit wen, input logic [2:0] mt,
                             input logic [31:0] addr, input logic [31:0] rs2);
        m_valid    = 1'b1;
        m_pc       = $urandom;
        m_imm      = $urandom;
        m_rd       = 5'($urandom);
        m_reg_wen  = 1'($urandom);
        m_reg_wsel = 2'($urandom);
        m_alu_out  = addr;
        m_mem_type = mt;
        m_mem_ren  = ren;
        m_mem_wen  = wen;
        m_rs2      = rs2;
    endtask

    task automatic drain();
        for (int i = 0; i < 40; i++) begin
            if (!busy && !out_v) return;
            m_valid     = 1'b0;
            w_ready     = 1'b1;
            dbus_gnt    = req_p;
            dbus_rvalid = data_p;
            dbus_rdata  = $urandom;
            cycle();
        end
        check_eq("drain_timeout", 32'(busy || out_v), 32'd0);
    endtask

    initial begin
        ld_types = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
        rst_n = 1'b0;
        set_instr(0, 0, 3'b000, 32'h0, 32'h0);
        m_valid = 1'b0; w_ready = 1'b1;
        dbus_gnt = 1'b0; dbus_rvalid = 1'b0; dbus_rdata = '0;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        cycle();
        check_eq("rst_w_pc", w_pc, 32'd0);
        check_eq("rst_w_mem_rdata", w_mem_rdata, 32'd0);
        check_eq("rst_dbus_addr", dbus_addr, 32'd0);
        rst_n = 1'b1;

        // Three back-to-back ALU ops.
        for (int i = 0; i < 3; i++) begin
            set_instr(0, 0, 3'($urandom), $urandom, $urandom);
            cycle();
        end
        m_valid = 1'b0;
        cycle();
        drain();

        // SB with grant held off for two cycles.
        set_instr(0, 1, 3'b000, 32'h0000_1003, 32'h0000_00A5);
        cycle();
        m_valid = 1'b0;
        cycle();
        cycle();
        check_eq("sb_addr", dbus_addr, 32'h0000_1000);
        check_eq("sb_be", 32'(dbus_be), 32'h8);
        check_eq("sb_wdata", dbus_wdata, 32'hA5A5_A5A5);
        dbus_gnt = 1'b1;
        cycle();
        dbus_gnt = 1'b0;
        check_eq("sb_wvalid", 32'(w_valid), 32'd1);
        drain();

        // LH at 0x2002, data three cycles after grant.
        set_instr(1, 0, 3'b001, 32'h0000_2002, $urandom);
        cycle();
        m_valid = 1'b0;
        dbus_gnt = 1'b1;
        cycle();
        dbus_gnt = 1'b0;
        cycle();
        cycle();
        dbus_rvalid = 1'b1; dbus_rdata = 32'h8001_1234;
        cycle();
        dbus_rvalid = 1'b0;
        check_eq("lh_rdata", w_mem_rdata, 32'h0000_8001);
        check_eq("lh_mem_type", 32'(w_mem_type), 32'd1);
        drain();

        // Load result stalled by the W stage for four cycles.
        set_instr(1, 0, 3'b010, 32'h0000_4000, 32'h0);
        cycle();
        m_valid = 1'b0;
        dbus_gnt = 1'b1;
        cycle();
        dbus_gnt = 1'b0;
        w_ready = 1'b0; dbus_rvalid = 1'b1; dbus_rdata = $urandom;
        cycle();
        dbus_rvalid = 1'b0;
        set_instr(0, 0, 3'b000, $urandom, $urandom);
        for (int i = 0; i < 4; i++) begin
            check_eq("stall_m_ready", 32'(m_ready), 32'd0);
            cycle();
        end
        w_ready = 1'b1;
        cycle();
        check_eq("stall_w_valid_clr", 32'(w_valid), 32'd0);
        check_eq("stall_next_ready", 32'(m_ready), 32'd1);
        cycle();
        m_valid = 1'b0;
        drain();

        // Reset while waiting for load data; the late rvalid must be dropped.
        set_instr(1, 0, 3'b010, 32'h0000_5000, 32'h0);
        cycle();
        m_valid = 1'b0;
        dbus_gnt = 1'b1;
        cycle();
        dbus_gnt = 1'b0;
        cycle();
        rst_n = 1'b0;
        cycle();
        rst_n = 1'b1;
        dbus_rvalid = 1'b1; dbus_rdata = $urandom;
        cycle();
        dbus_rvalid = 1'b0;
        check_eq("late_rvalid_w_valid", 32'(w_valid), 32'd0);
        check_eq("late_rvalid_m_ready", 32'(m_ready), 32'd1);
        cycle();

        // Misaligned LW at 0x3001.
        set_instr(1, 0, 3'b010, 32'h0000_3001, 32'h0);
        m_reg_wen = 1'b1;
        cycle();
        m_valid = 1'b0;
`ifdef CORE_MEM_MISALIGN_EN
        check_eq("mis_no_req", 32'(dbus_req), 32'd0);
        check_eq("mis_fault", 32'(mem_fault), 32'd1);
        check_eq("mis_reg_wen", 32'(w_reg_wen), 32'd0);
        check_eq("mis_w_valid", 32'(w_valid), 32'd1);
`else
        check_eq("mis_addr", dbus_addr, 32'h0000_3000);
        check_eq("mis_req", 32'(dbus_req), 32'd1);
`endif
        drain();

        // Random traffic.
        for (int c = 0; c < 4000; c++) begin
            int k;
            rst_n       = ($urandom_range(0, 299) != 0);
            w_ready     = ($urandom_range(0, 3) != 0);
            dbus_gnt    = req_p && ($urandom_range(0, 1) == 1);
            dbus_rvalid = data_p ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 9) == 0);
            dbus_rdata  = $urandom;
            if ($urandom_range(0, 3) != 0) begin
                k = $urandom_range(0, 9);
                if (k < 4)      set_instr(0, 0, 3'($urandom), $urandom, $urandom);
                else if (k < 7) set_instr(1, 0, ld_types[$urandom_range(0, 4)], $urandom, $urandom);
                else if (k < 9) set_instr(0, 1, 3'($urandom_range(0, 2)), $urandom, $urandom);
                else            set_instr(1, 1, 3'($urandom_range(0, 2)), $urandom, $urandom);
            end else begin
                m_valid = 1'b0;
            end
            cycle();
        end
        rst_n = 1'b1;
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
